dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Direct-mapped, write-back data cache between the pipelined datapath's data-memory port and multi-cycle main memory. Responds to the datapath's `re_dm`/`we_dm`/`addr_DM`/`wd_dm` requests and returns `rd_DM`. Hits complete in the request cycle. Misses raise `stall` while a dirty victim is written back and the line is refilled over a request/ready handshake.

## Interface
Parameters:
- LINES, 8: number of lines; index width is log2(LINES).
- WORDS, 4: 16-bit words per line; offset width is log2(WORDS); memory beat width is 16*WORDS.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- re  in  1  CPU read request (datapath `re_dm`)
- we  in  1  CPU write request (datapath `we_dm`); has priority over `re`
- addr  in  16  CPU word address: tag[15:5], index[4:2], offset[1:0] at default parameters
- wdata  in  16  CPU write data
- rdata  out  16  CPU read data; combinational from the line store
- stall  out  1  combinational; high while the current request cannot complete
- mem_re  out  1  main-memory line read request
- mem_we  out  1  main-memory line write request
- mem_addr  out  16  line-aligned address; offset bits are 0
- mem_wdata  out  16*WORDS  victim line; word 0 in bits [15:0]
- mem_rdata  in  16*WORDS  fill line; valid when `mem_rdy` is high
- mem_rdy  in  1  single-cycle completion pulse for the outstanding request

## Operation
- Per line: valid, dirty, tag, and WORDS data words.
- hit = valid[index] && (tag[index] == addr tag).
- FSM states: IDLE, WB, FILL.
- IDLE, no request: `stall` = 0 and `rdata` = 0.
- IDLE, read hit: `rdata` = word[index][offset], `stall` = 0.
- IDLE, write hit: `stall` = 0. At the clock edge, word[index][offset] takes `wdata` and dirty is set.
- IDLE, miss: `stall` = 1. Next state is WB if the victim is valid and dirty, otherwise FILL.
- WB:
  - `mem_we` = 1, `mem_addr` = {victim tag, index, 0}, `mem_wdata` = victim line.
  - Held stable until `mem_rdy`, then go to FILL.
- FILL:
  - `mem_re` = 1, `mem_addr` = {req tag, index, 0}.
  - On `mem_rdy`: load the line from `mem_rdata`, set tag, valid = 1, dirty = 0, go to IDLE.
- After FILL, the held request hits in IDLE and completes there. A write at this point sets dirty.
- `stall` = 1 in WB and FILL throughout, including the `mem_rdy` cycle.
- The CPU holds `addr`/`we`/`re`/`wdata` constant while `stall` = 1. The block does not re-sample them in WB/FILL; it uses the index and tag captured on the miss.
- `mem_rdy` while `mem_re` = `mem_we` = 0 is ignored.
- `mem_re` and `mem_we` are never high together.

## Timing
- Reset values:
  - state = IDLE; all valid and dirty = 0.
  - `mem_re` = `mem_we` = 0, `mem_addr` = 0.
  - `stall` = 0 and `rdata` = 0 when no request is present.
- Data arrays are not reset.
- Reset mid-WB/FILL: the transaction is abandoned and all lines are invalidated. Dirty data is lost by design. The memory controller is reset by the same `rst`.
- Hit latency: 0 cycles (combinational `rdata`/`stall`). The write commits at the edge ending the request cycle.
- Clean miss: `stall` high for (fill latency + 1) cycles. FILL spans the cycles up to and including `mem_rdy`; the completing hit takes one more IDLE cycle, during which `stall` = 0.
- Dirty miss: the WB duration is added before FILL.
- Request/ready: `mem_re`/`mem_we` and `mem_addr` are registered outputs. They rise on the edge that enters WB/FILL and fall on the edge after `mem_rdy`.

## Configuration
- Macro: DCACHE_STATS_EN.
- When defined, adds outputs `hit_cnt` [15:0] and `miss_cnt` [15:0]. Both reset to 0 and saturate at 16'hFFFF.
  - `miss_cnt` increments once per IDLE→WB/FILL transition.
  - `hit_cnt` increments on each IDLE hit that did not immediately follow a FILL, tracked by a one-bit "just filled" flag.
- When undefined: no counters, no ports, no flag.

## Structure
- Package `dcache_pkg`:
  - state enum {IDLE, WB, FILL}
  - TAG_W, IDX_W, OFF_W localparams derived from defaults
  - `line_t` packed array of WORDS×16 bits
  - address-field extraction functions
- Sub-module `dcache_line_store`: valid/dirty/tag/data arrays with async read, one word-write port, one line-write port. The write port clears dirty and sets valid.
- FSM, counters, and memory handshake live in `dcache_ctrl`.

## Test plan
- Cold read: after reset, `re` with `addr`=16'h0013; memory returns a line with word3=16'hBEEF after 3 cycles.
  - `stall` high 4 cycles, `mem_addr`=16'h0010, then `rdata`=16'hBEEF with `stall`=0.
  - `miss_cnt`=1, `hit_cnt`=0.
- Write hit then read: `we` `addr`=16'h0011 `wdata`=16'h1234 (line resident).
  - `stall`=0 throughout; the next-cycle read of 16'h0011 returns 16'h1234; dirty[4]=1.
- Dirty eviction: after the above, read 16'h0111 (same index 4, new tag).
  - First `mem_we`=1 with `mem_addr`=16'h0010 and `mem_wdata` word1=16'h1234.
  - After `mem_rdy`, `mem_re`=1 with `mem_addr`=16'h0110; never both high together.
- Clean eviction: read a different tag on a clean, valid line.
  - No `mem_we` cycle; FILL only.
- Reset mid-FILL: assert `rst`=0 while `mem_re`=1.
  - Next cycle `mem_re`=0 and state IDLE; a subsequent read of the prior line misses.
- Stats saturation (DCACHE_STATS_EN): issue 65540 hits to one line.
  - `hit_cnt`=16'hFFFF, `miss_cnt`=1.

Source files
------------

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types, geometry and address helpers for the direct-mapped data cache
package dcache_pkg;

    localparam int LINES_DEF = 8;
    localparam int WORDS_DEF = 4;
    localparam int IDX_W     = $clog2(LINES_DEF);
    localparam int OFF_W     = $clog2(WORDS_DEF);
    localparam int TAG_W     = 16 - IDX_W - OFF_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_FILL = 2'd2
    } state_t;

    typedef logic [WORDS_DEF-1:0][15:0] line_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic [OFF_W-1:0] off;
    } addr_fields_t;

    function automatic addr_fields_t split_addr(input logic [15:0] addr);
        return addr_fields_t'(addr);
    endfunction

    function automatic logic [15:0] line_addr(input logic [TAG_W-1:0] tag,
                                              input logic [IDX_W-1:0] idx);
        return {tag, idx, {OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_if.sv
// rtl/dcache_if.sv - CPU data port plus main-memory line handshake, bundled for the cache
interface dcache_if #(
    parameter int WORDS = 4
);
    logic                   re;
    logic                   we;
    logic [15:0]            addr;
    logic [15:0]            wdata;
    logic [15:0]            rdata;
    logic                   stall;
    logic                   mem_re;
    logic                   mem_we;
    logic [15:0]            mem_addr;
    logic [16*WORDS-1:0]    mem_wdata;
    logic [16*WORDS-1:0]    mem_rdata;
    logic                   mem_rdy;

    modport slave (
        input  re, we, addr, wdata, mem_rdata, mem_rdy,
        output rdata, stall, mem_re, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output re, we, addr, wdata, mem_rdata, mem_rdy,
        input  rdata, stall, mem_re, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_line_store.sv
// rtl/dcache_line_store.sv - valid/dirty/tag/data arrays: async read, word-write and line-fill ports
module dcache_line_store #(
    parameter int LINES = 8,
    parameter int WORDS = 4,
    parameter int TAG_W = 11,
    parameter int IDX_W = $clog2(LINES),
    parameter int OFF_W = $clog2(WORDS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [IDX_W-1:0]            rd_idx,
    output logic                        rd_valid,
    output logic                        rd_dirty,
    output logic [TAG_W-1:0]            rd_tag,
    output logic [WORDS-1:0][15:0]      rd_line,
    input  logic                        ww_en,
    input  logic [IDX_W-1:0]            ww_idx,
    input  logic [OFF_W-1:0]            ww_off,
    input  logic [15:0]                 ww_data,
    input  logic                        lw_en,
    input  logic [IDX_W-1:0]            lw_idx,
    input  logic [TAG_W-1:0]            lw_tag,
    input  logic [WORDS-1:0][15:0]      lw_data
);

    logic [LINES-1:0]                   valid_q, valid_d;
    logic [LINES-1:0]                   dirty_q, dirty_d;
    logic [LINES-1:0][TAG_W-1:0]        tag_q, tag_d;
    logic [LINES-1:0][WORDS-1:0][15:0]  data_q, data_d;

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (ww_en) begin
            data_d[ww_idx][ww_off] = ww_data;
            dirty_d[ww_idx]        = 1'b1;
        end
        // A fill always lands clean; the controller never fills and word-writes in one cycle.
        if (lw_en) begin
            data_d[lw_idx]  = lw_data;
            tag_d[lw_idx]   = lw_tag;
            valid_d[lw_idx] = 1'b1;
            dirty_d[lw_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back data cache controller (FSM + memory handshake)
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES = LINES_DEF,
    parameter int WORDS = WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    dcache_if.slave     bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
`endif
);

    localparam int IB = $clog2(LINES);
    localparam int OB = $clog2(WORDS);
    localparam int TB = 16 - IB - OB;

    logic [TB-1:0]              req_tag;
    logic [IB-1:0]              req_idx;
    logic [OB-1:0]              req_off;
    logic [IB-1:0]              rd_idx;
    logic                       st_valid, st_dirty;
    logic [TB-1:0]              st_tag;
    logic [WORDS-1:0][15:0]     st_line;

    state_t                     state_q, state_d;
    logic                       mem_re_q, mem_re_d;
    logic                       mem_we_q, mem_we_d;
    logic [15:0]                mem_addr_q, mem_addr_d;
    logic [IB-1:0]              miss_idx_q, miss_idx_d;
    logic [TB-1:0]              miss_tag_q, miss_tag_d;

    logic                       req, idle, hit, idle_hit, idle_miss;
    logic                       ww_en, lw_en;

    assign req_tag = bus.addr[15 -: TB];
    assign req_idx = bus.addr[OB +: IB];
    assign req_off = bus.addr[OB-1:0];

    assign idle      = (state_q == ST_IDLE);
    assign req       = bus.re | bus.we;
    // Outside IDLE the store is addressed by the captured miss, not the live CPU address.
    assign rd_idx    = idle ? req_idx : miss_idx_q;
    assign hit       = st_valid && (st_tag == req_tag);
    assign idle_hit  = idle && req && hit;
    assign idle_miss = idle && req && !hit;

    assign ww_en = idle_hit && bus.we;
    assign lw_en = (state_q == ST_FILL) && bus.mem_rdy;

    assign bus.stall     = !idle || idle_miss;
    assign bus.rdata     = idle_hit ? st_line[req_off] : 16'h0000;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = st_line;

    dcache_line_store #(
        .LINES (LINES),
        .WORDS (WORDS),
        .TAG_W (TB),
        .IDX_W (IB),
        .OFF_W (OB)
    ) u_store (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (rd_idx),
        .rd_valid (st_valid),
        .rd_dirty (st_dirty),
        .rd_tag   (st_tag),
        .rd_line  (st_line),
        .ww_en    (ww_en),
        .ww_idx   (req_idx),
        .ww_off   (req_off),
        .ww_data  (bus.wdata),
        .lw_en    (lw_en),
        .lw_idx   (miss_idx_q),
        .lw_tag   (miss_tag_q),
        .lw_data  (bus.mem_rdata)
    );

    always_comb begin
        state_d    = state_q;
        mem_re_d   = mem_re_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        miss_idx_d = miss_idx_q;
        miss_tag_d = miss_tag_q;
        case (state_q)
            ST_IDLE: begin
                if (idle_miss) begin
                    miss_idx_d = req_idx;
                    miss_tag_d = req_tag;
                    if (st_valid && st_dirty) begin
                        state_d    = ST_WB;
                        mem_we_d   = 1'b1;
                        mem_addr_d = {st_tag, req_idx, {OB{1'b0}}};
                    end else begin
                        state_d    = ST_FILL;
                        mem_re_d   = 1'b1;
                        mem_addr_d = {req_tag, req_idx, {OB{1'b0}}};
                    end
                end
            end
            ST_WB: begin
                if (bus.mem_rdy) begin
                    state_d    = ST_FILL;
                    mem_we_d   = 1'b0;
                    mem_re_d   = 1'b1;
                    mem_addr_d = {miss_tag_q, miss_idx_q, {OB{1'b0}}};
                end
            end
            ST_FILL: begin
                if (bus.mem_rdy) begin
                    state_d    = ST_IDLE;
                    mem_re_d   = 1'b0;
                    mem_addr_d = 16'h0000;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                mem_re_d   = 1'b0;
                mem_we_d   = 1'b0;
                mem_addr_d = 16'h0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            mem_re_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= 16'h0000;
            miss_idx_q <= '0;
            miss_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_re_q   <= mem_re_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            miss_idx_q <= miss_idx_d;
            miss_tag_q <= miss_tag_d;
        end
    end

`ifdef DCACHE_STATS_EN
    logic        just_filled_q, just_filled_d;
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    // The hit that completes a refilled request was already counted as a miss.
    always_comb begin
        just_filled_d = lw_en;
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        if (idle_hit && !just_filled_q && (hit_cnt_q != 16'hFFFF))
            hit_cnt_d = hit_cnt_q + 16'd1;
        if (idle_miss && (miss_cnt_q != 16'hFFFF))
            miss_cnt_d = miss_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            just_filled_q <= 1'b0;
            hit_cnt_q     <= 16'h0000;
            miss_cnt_q    <= 16'h0000;
        end else begin
            just_filled_q <= just_filled_d;
            hit_cnt_q     <= hit_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - self-checking bench: flat-memory reference model, latency-randomised memory responder
module tb_dcache_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dcache_if #(.WORDS(4)) mif();

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    dcache_ctrl #(.LINES(8), .WORDS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (mif.slave)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int mem_lat  = 3;

    logic [63:0] mem_bk [logic [15:0]];
    logic [63:0] ref_bk [logic [15:0]];
    logic [63:0] ref_line [8];
    int          ref_tag [8];
    bit          ref_valid [8];
    bit          ref_dirty [8];

    bit          wb_seen, fill_seen, fill_after_wb;
    logic [15:0] wb_addr, fill_addr;
    logic [63:0] wb_data;
    int          both_high = 0;

    function automatic logic [63:0] init_line(input logic [15:0] la);
        logic [63:0] l;
        for (int w = 0; w < 4; w++) l[w*16 +: 16] = (la + 16'(w)) ^ 16'h6B3D;
        return l;
    endfunction

    function automatic logic [63:0] mem_get(input logic [15:0] la);
        if (!mem_bk.exists(la)) mem_bk[la] = init_line(la);
        return mem_bk[la];
    endfunction

    function automatic logic [63:0] ref_get(input logic [15:0] la);
        if (!ref_bk.exists(la)) ref_bk[la] = init_line(la);
        return ref_bk[la];
    endfunction

    // Main memory: answers each request after mem_lat cycles, records what it saw.
    initial begin
        int cnt;
        cnt = 0;
        mif.mem_rdy   = 1'b0;
        mif.mem_rdata = '0;
        forever begin
            @(negedge clk);
            mif.mem_rdy = 1'b0;
            if (!rst || !(mif.mem_re || mif.mem_we)) begin
                cnt = 0;
            end else begin
                if (mif.mem_re && mif.mem_we) both_high++;
                if (mif.mem_we && !wb_seen) begin
                    wb_seen = 1; wb_addr = mif.mem_addr; wb_data = mif.mem_wdata;
                end
                if (mif.mem_re && !fill_seen) begin
                    fill_seen = 1; fill_after_wb = wb_seen; fill_addr = mif.mem_addr;
                end
                cnt++;
                if (cnt >= mem_lat) begin
                    cnt = 0;
                    mif.mem_rdy = 1'b1;
                    if (mif.mem_we) mem_bk[mif.mem_addr] = mif.mem_wdata;
                    else mif.mem_rdata = mem_get(mif.mem_addr);
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_mon();
        wb_seen = 0; fill_seen = 0; fill_after_wb = 0;
        wb_addr = 16'h0; fill_addr = 16'h0; wb_data = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin ref_valid[i] = 0; ref_dirty[i] = 0; end
    endtask

    // The CPU sees a flat memory; the model also tracks residency to predict stall length.
    task automatic model_access(input bit is_we, input logic [15:0] a, input logic [15:0] d,
                                input int lat, output logic [15:0] exp_rd, output int exp_stalls);
        int idx, tag, off;
        logic [15:0] va;
        off = int'(a) % 4;
        idx = (int'(a) / 4) % 8;
        tag = int'(a) / 32;
        exp_rd = 16'h0;
        if (ref_valid[idx] && ref_tag[idx] == tag) begin
            exp_stalls = 0;
        end else begin
            exp_stalls = lat + 1;
            if (ref_valid[idx] && ref_dirty[idx]) begin
                va = 16'(ref_tag[idx] * 32 + idx * 4);
                ref_bk[va] = ref_line[idx];
                exp_stalls = 2 * lat + 1;
            end
            ref_line[idx]  = ref_get(16'(tag * 32 + idx * 4));
            ref_valid[idx] = 1; ref_tag[idx] = tag; ref_dirty[idx] = 0;
        end
        if (is_we) begin
            ref_line[idx][off*16 +: 16] = d;
            ref_dirty[idx] = 1;
        end else begin
            exp_rd = ref_line[idx][off*16 +: 16];
        end
    endtask

    task automatic cpu_access(input bit is_we, input logic [15:0] a, input logic [15:0] d,
                              output logic [15:0] rd, output int stalls);
        @(negedge clk);
        mif.we = is_we; mif.re = !is_we; mif.addr = a; mif.wdata = d;
        #1;
        stalls = 0;
        while (mif.stall === 1'b1 && stalls < 300) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        rd = mif.rdata;
        @(posedge clk);
        #1;
        mif.re = 1'b0; mif.we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; mif.re = 1'b0; mif.we = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++; if (mif.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", mif.stall); end
        n_checks++; if (mif.rdata !== 16'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0000", mif.rdata); end
        n_checks++; if (mif.mem_re !== 1'b0) begin n_fail++; $display("FAIL reset_mem_re: got %b expected 0", mif.mem_re); end
        n_checks++; if (mif.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b expected 0", mif.mem_we); end
        n_checks++; if (mif.mem_addr !== 16'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0000", mif.mem_addr); end
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        n_checks++; if (mif.stall !== 1'b0) begin n_fail++; $display("FAIL idle_stall: got %b expected 0", mif.stall); end
`ifdef DCACHE_STATS_EN
        n_checks++; if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %h/%h expected 0000/0000", hit_cnt, miss_cnt); end
`endif
    endtask

    task automatic test_cold_read();
        logic [63:0] l;
        logic [15:0] rd, erd;
        int st, est;
        l = init_line(16'h0010);
        l[63:48] = 16'hBEEF;
        mem_bk[16'h0010] = l;
        ref_bk[16'h0010] = l;
        mem_lat = 3;
        clear_mon();
        model_access(0, 16'h0013, 16'h0, 3, erd, est);
        cpu_access(0, 16'h0013, 16'h0, rd, st);
        n_checks++; if (st !== 4) begin n_fail++; $display("FAIL cold_stall_cycles: got %0d expected 4", st); end
        n_checks++; if (fill_addr !== 16'h0010) begin n_fail++; $display("FAIL cold_mem_addr: got %h expected 0010", fill_addr); end
        n_checks++; if (rd !== 16'hBEEF) begin n_fail++; $display("FAIL cold_rdata: got %h expected beef", rd); end
        n_checks++; if (wb_seen !== 1'b0) begin n_fail++; $display("FAIL cold_no_wb: got %b expected 0", wb_seen); end
`ifdef DCACHE_STATS_EN
        n_checks++; if (miss_cnt !== 16'd1) begin n_fail++; $display("FAIL cold_miss_cnt: got %0d expected 1", miss_cnt); end
        n_checks++; if (hit_cnt !== 16'd0) begin n_fail++; $display("FAIL cold_hit_cnt: got %0d expected 0", hit_cnt); end
`endif
    endtask

    task automatic test_write_hit();
        logic [15:0] rd, erd;
        int st, est;
        model_access(1, 16'h0011, 16'h1234, mem_lat, erd, est);
        cpu_access(1, 16'h0011, 16'h1234, rd, st);
        n_checks++; if (st !== 0) begin n_fail++; $display("FAIL wr_hit_stall: got %0d expected 0", st); end
        model_access(0, 16'h0011, 16'h0, mem_lat, erd, est);
        cpu_access(0, 16'h0011, 16'h0, rd, st);
        n_checks++; if (st !== 0) begin n_fail++; $display("FAIL rd_after_wr_stall: got %0d expected 0", st); end
        n_checks++; if (rd !== 16'h1234) begin n_fail++; $display("FAIL rd_after_wr_data: got %h expected 1234", rd); end
    endtask

    task automatic test_dirty_evict();
        logic [15:0] rd, erd;
        int st, est;
        mem_lat = 2;
        clear_mon();
        model_access(0, 16'h0111, 16'h0, 2, erd, est);
        cpu_access(0, 16'h0111, 16'h0, rd, st);
        n_checks++; if (wb_seen !== 1'b1) begin n_fail++; $display("FAIL dirty_wb_seen: got %b expected 1", wb_seen); end
        n_checks++; if (wb_addr !== 16'h0010) begin n_fail++; $display("FAIL dirty_wb_addr: got %h expected 0010", wb_addr); end
        n_checks++; if (wb_data[31:16] !== 16'h1234) begin n_fail++; $display("FAIL dirty_wb_word1: got %h expected 1234", wb_data[31:16]); end
        n_checks++; if (fill_after_wb !== 1'b1) begin n_fail++; $display("FAIL dirty_fill_order: got %b expected 1", fill_after_wb); end
        n_checks++; if (fill_addr !== 16'h0110) begin n_fail++; $display("FAIL dirty_fill_addr: got %h expected 0110", fill_addr); end
        n_checks++; if (both_high !== 0) begin n_fail++; $display("FAIL dirty_both_high: got %0d expected 0", both_high); end
        n_checks++; if (st !== 5) begin n_fail++; $display("FAIL dirty_stall_cycles: got %0d expected 5", st); end
        n_checks++; if (rd !== erd) begin n_fail++; $display("FAIL dirty_rdata: got %h expected %h", rd, erd); end
    endtask

    task automatic test_clean_evict();
        logic [15:0] rd, erd;
        int st, est;
        mem_lat = 3;
        clear_mon();
        model_access(0, 16'h0011, 16'h0, 3, erd, est);
        cpu_access(0, 16'h0011, 16'h0, rd, st);
        n_checks++; if (wb_seen !== 1'b0) begin n_fail++; $display("FAIL clean_no_wb: got %b expected 0", wb_seen); end
        n_checks++; if (st !== 4) begin n_fail++; $display("FAIL clean_stall_cycles: got %0d expected 4", st); end
        n_checks++; if (rd !== 16'h1234) begin n_fail++; $display("FAIL clean_rdata: got %h expected 1234", rd); end
    endtask

    task automatic test_reset_mid_fill();
        logic [15:0] rd, erd;
        int st, est, waited;
        mem_lat = 10;
        @(negedge clk);
        mif.re = 1'b1; mif.addr = 16'h0222;
        waited = 0;
        while (mif.mem_re !== 1'b1 && waited < 5) begin @(negedge clk); waited++; end
        n_checks++; if (mif.mem_re !== 1'b1) begin n_fail++; $display("FAIL mid_fill_req: got %b expected 1", mif.mem_re); end
        rst = 1'b0; mif.re = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (mif.mem_re !== 1'b0) begin n_fail++; $display("FAIL mid_fill_mem_re: got %b expected 0", mif.mem_re); end
        n_checks++; if (mif.mem_addr !== 16'h0) begin n_fail++; $display("FAIL mid_fill_mem_addr: got %h expected 0000", mif.mem_addr); end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++; if (mif.stall !== 1'b0) begin n_fail++; $display("FAIL mid_fill_idle: got %b expected 0", mif.stall); end
        mem_lat = 2;
        model_access(0, 16'h0011, 16'h0, 2, erd, est);
        cpu_access(0, 16'h0011, 16'h0, rd, st);
        n_checks++; if (st !== 3) begin n_fail++; $display("FAIL post_reset_miss: got %0d expected 3", st); end
        n_checks++; if (rd !== erd) begin n_fail++; $display("FAIL post_reset_rdata: got %h expected %h", rd, erd); end
    endtask

    task automatic test_random();
        logic [15:0] a, d, rd, erd;
        bit w;
        int st, est, lat;
        for (int i = 0; i < 300; i++) begin
            w   = ($urandom_range(0, 2) == 0);
            a   = 16'($urandom_range(0, 3) * 32 + $urandom_range(0, 31));
            d   = 16'($urandom);
            lat = $urandom_range(1, 4);
            mem_lat = lat;
            model_access(w, a, d, lat, erd, est);
            cpu_access(w, a, d, rd, st);
            n_checks++; if (st !== est) begin n_fail++; $display("FAIL rand_stall[%0d] addr %h: got %0d expected %0d", i, a, st, est); end
            if (!w) begin
                n_checks++; if (rd !== erd) begin n_fail++; $display("FAIL rand_rdata[%0d] addr %h: got %h expected %h", i, a, rd, erd); end
            end
        end
        n_checks++; if (both_high !== 0) begin n_fail++; $display("FAIL rand_both_high: got %0d expected 0", both_high); end
    endtask

`ifdef DCACHE_STATS_EN
    task automatic test_stats_saturation();
        logic [15:0] rd, erd;
        int st, est;
        do_reset();
        mem_lat = 2;
        model_access(0, 16'h0013, 16'h0, 2, erd, est);
        cpu_access(0, 16'h0013, 16'h0, rd, st);
        @(negedge clk);
        mif.re = 1'b1; mif.addr = 16'h0013;
        repeat (65540) @(posedge clk);
        @(negedge clk);
        mif.re = 1'b0;
        n_checks++; if (hit_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hit_cnt: got %h expected ffff", hit_cnt); end
        n_checks++; if (miss_cnt !== 16'd1) begin n_fail++; $display("FAIL sat_miss_cnt: got %0d expected 1", miss_cnt); end
    endtask
`endif

    initial begin
        mif.re = 1'b0; mif.we = 1'b0; mif.addr = 16'h0; mif.wdata = 16'h0;
        clear_mon();
        model_reset();
        test_reset();
        test_cold_read();
        test_write_hit();
        test_dirty_evict();
        test_clean_evict();
        test_reset_mid_fill();
        test_random();
`ifdef DCACHE_STATS_EN
        test_stats_saturation();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
